// File: rtl/ltf_seq_gen.sv
// LTF sequence generator: scales frequency-domain ROM samples into an external IFFT,
// captures the time-domain result and replays it as cyclic-prefixed, polarity-coded symbols.
module ltf_seq_gen #(
    parameter int IQ_W    = 16,
    parameter int LG_N    = 6,
    parameter int CP_LEN  = 16,
    parameter int MAX_SYM = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [2:0]                n_sym,
    input  logic [MAX_SYM-1:0]        polarity,
    input  logic [2*(2**LG_N)-1:0]    obf_coeff,
    output logic [LG_N-1:0]           freq_addr,
    input  logic [2*IQ_W-1:0]         freq_data,
    output logic                      ifft_in_valid,
    input  logic                      ifft_in_ready,
    output logic [2*IQ_W-1:0]         ifft_in_data,
    output logic                      ifft_in_last,
    input  logic                      ifft_out_valid,
    input  logic [2*IQ_W-1:0]         ifft_out_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [2*IQ_W-1:0]         m_data,
    output logic                      m_last,
    output logic                      busy,
    output logic                      done
);

    localparam int N      = 2**LG_N;
    localparam int W      = 2*IQ_W;
    localparam int SLEN   = N + CP_LEN;
    localparam int PW     = $clog2(SLEN) + 1;
    localparam int NS_CAP = (MAX_SYM > 7) ? 7 : MAX_SYM;

    localparam logic [LG_N-1:0] K_LAST = LG_N'(N-1);
    localparam logic [PW-1:0]   P_LAST = PW'(SLEN-1);
    localparam logic [PW-1:0]   RD_OFF = PW'(N-CP_LEN);
    localparam logic [2:0]      NS_MAX = 3'(NS_CAP);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CAPTURE = 3'd2,
        S_PLAY    = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [LG_N-1:0]     k_q, k_d, c_q, c_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic [2:0]          sym_q, sym_d, nsym_q, nsym_d;
    logic [MAX_SYM-1:0]  pol_q, pol_d;
    logic [2*N-1:0]      coeff_q, coeff_d;
    logic                gen_done_q, gen_done_d;
    logic                mv_q, mv_d, ml_q, ml_d;
    logic [W-1:0]        md_q, md_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [W-1:0]        buf_q [N];

    logic [1:0]          code_s;
    logic [W-1:0]        scaled_s;
    logic [LG_N-1:0]     rd_idx_s;
    logic [W-1:0]        rd_word_s;
    logic [W-1:0]        play_word_s;
    logic                pol_bit_s;
    logic                last_sym_s;
    logic                last_pos_s;
    logic [2:0]          nsym_in_s;
    logic                in_load_s;

    function automatic logic [IQ_W-1:0] scale_comp(input logic [IQ_W-1:0] x, input logic [1:0] code);
        logic signed [IQ_W-1:0] sx;
        sx = x;
        case (code)
            2'b00:   scale_comp = x;
            2'b01:   scale_comp = sx >>> 3'd3;
            2'b10:   scale_comp = sx >>> 3'd1;
            2'b11:   scale_comp = sx >>> 3'd2;
            default: scale_comp = x;
        endcase
    endfunction

    // The most negative value has no positive twin, so it saturates.
    function automatic logic [IQ_W-1:0] neg_sat(input logic [IQ_W-1:0] x);
        if (x == {1'b1, {(IQ_W-1){1'b0}}}) begin
            neg_sat = {1'b0, {(IQ_W-1){1'b1}}};
        end else begin
            neg_sat = ~x + {{(IQ_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Datapath helpers: subcarrier scaling and cyclic-prefix buffer addressing.
    always_comb begin
        code_s     = coeff_q[{k_q, 1'b0} +: 2];
        scaled_s   = {scale_comp(freq_data[W-1:IQ_W], code_s), scale_comp(freq_data[IQ_W-1:0], code_s)};
        rd_idx_s   = LG_N'(pos_q + RD_OFF);
        rd_word_s  = buf_q[rd_idx_s];
        pol_bit_s  = |(pol_q & ({{(MAX_SYM-1){1'b0}}, 1'b1} << sym_q));
        if (pol_bit_s) begin
            play_word_s = {neg_sat(rd_word_s[W-1:IQ_W]), neg_sat(rd_word_s[IQ_W-1:0])};
        end else begin
            play_word_s = rd_word_s;
        end
        last_sym_s = (sym_q + 3'd1) == nsym_q;
        last_pos_s = pos_q == P_LAST;
        nsym_in_s  = (n_sym > NS_MAX) ? NS_MAX : n_sym;
    end

    // Next-state and counter logic for the whole sequence.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        c_d        = c_q;
        pos_d      = pos_q;
        sym_d      = sym_q;
        nsym_d     = nsym_q;
        pol_d      = pol_q;
        coeff_d    = coeff_q;
        gen_done_d = gen_done_q;
        mv_d       = mv_q;
        ml_d       = ml_q;
        md_d       = md_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nsym_d     = nsym_in_s;
                    pol_d      = polarity;
                    coeff_d    = obf_coeff;
                    k_d        = {LG_N{1'b0}};
                    c_d        = {LG_N{1'b0}};
                    pos_d      = {PW{1'b0}};
                    sym_d      = 3'd0;
                    gen_done_d = 1'b0;
                    mv_d       = 1'b0;
                    ml_d       = 1'b0;
                    state_d    = (nsym_in_s == 3'd0) ? S_FINISH : S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (ifft_in_ready) begin
                    if (k_q == K_LAST) begin
                        k_d     = {LG_N{1'b0}};
                        state_d = S_CAPTURE;
                    end else begin
                        k_d = k_q + {{(LG_N-1){1'b0}}, 1'b1};
                    end
                end else begin
                    k_d = k_q;
                end
            end
            S_CAPTURE: begin
                if (ifft_out_valid) begin
                    if (c_q == K_LAST) begin
                        c_d     = {LG_N{1'b0}};
                        state_d = S_PLAY;
                    end else begin
                        c_d = c_q + {{(LG_N-1){1'b0}}, 1'b1};
                    end
                end else begin
                    c_d = c_q;
                end
            end
            S_PLAY: begin
                // Output register refills in the same cycle it drains, so m_ready=1 sees no gaps.
                if (!gen_done_q && (!mv_q || m_ready)) begin
                    mv_d = 1'b1;
                    md_d = play_word_s;
                    ml_d = last_sym_s && last_pos_s;
                    if (last_pos_s) begin
                        pos_d = {PW{1'b0}};
                        if (last_sym_s) begin
                            gen_done_d = 1'b1;
                        end else begin
                            sym_d = sym_q + 3'd1;
                        end
                    end else begin
                        pos_d = pos_q + {{(PW-1){1'b0}}, 1'b1};
                    end
                end else if (mv_q && m_ready) begin
                    mv_d = 1'b0;
                    ml_d = 1'b0;
                    if (gen_done_q) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_PLAY;
                    end
                end else begin
                    mv_d = mv_q;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = state_d != S_IDLE;
        done_d = state_d == S_FINISH;
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            k_q        <= {LG_N{1'b0}};
            c_q        <= {LG_N{1'b0}};
            pos_q      <= {PW{1'b0}};
            sym_q      <= 3'd0;
            nsym_q     <= 3'd0;
            pol_q      <= {MAX_SYM{1'b0}};
            coeff_q    <= {(2*N){1'b0}};
            gen_done_q <= 1'b0;
            mv_q       <= 1'b0;
            ml_q       <= 1'b0;
            md_q       <= {W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            c_q        <= c_d;
            pos_q      <= pos_d;
            sym_q      <= sym_d;
            nsym_q     <= nsym_d;
            pol_q      <= pol_d;
            coeff_q    <= coeff_d;
            gen_done_q <= gen_done_d;
            mv_q       <= mv_d;
            ml_q       <= ml_d;
            md_q       <= md_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Capture buffer; contents survive reset.
    always_ff @(posedge clk) begin
        if (state_q == S_CAPTURE && ifft_out_valid) begin
            buf_q[c_q] <= ifft_out_data;
        end
    end

    // Reset gates the outputs so no handshake can complete in the reset cycle itself.
    assign in_load_s     = (state_q == S_LOAD) & ~reset;
    assign freq_addr     = reset ? {LG_N{1'b0}} : k_q;
    assign ifft_in_valid = in_load_s;
    assign ifft_in_last  = in_load_s & (k_q == K_LAST);
    assign ifft_in_data  = in_load_s ? scaled_s : {W{1'b0}};
    assign m_valid       = mv_q & ~reset;
    assign m_last        = ml_q & ~reset;
    assign m_data        = reset ? {W{1'b0}} : md_q;
    assign busy          = busy_q & ~reset;
    assign done          = done_q & ~reset;

endmodule

// File: tb/tb_ltf_seq_gen.sv
// Bench for ltf_seq_gen: identity IFFT model, random ROM/throttling, and a
// reference model that builds the expected sample stream directly from the rules.
module tb_ltf_seq_gen;
    localparam int IQ_W = 16;
    localparam int LG_N = 6;
    localparam int N    = 64;
    localparam int CP   = 16;
    localparam int MS   = 4;
    localparam int W    = 32;
    localparam int SL   = N + CP;

    logic            clk = 1'b0;
    logic            reset, start;
    logic [2:0]      n_sym;
    logic [MS-1:0]   polarity;
    logic [2*N-1:0]  obf_coeff;
    logic [LG_N-1:0] freq_addr;
    logic [W-1:0]    freq_data;
    logic            ifft_in_valid, ifft_in_ready, ifft_in_last;
    logic [W-1:0]    ifft_in_data;
    logic            ifft_out_valid;
    logic [W-1:0]    ifft_out_data;
    logic            m_valid, m_ready, m_last, busy, done;
    logic [W-1:0]    m_data;

    ltf_seq_gen #(.IQ_W(IQ_W), .LG_N(LG_N), .CP_LEN(CP), .MAX_SYM(MS)) dut (
        .clk(clk), .reset(reset), .start(start), .n_sym(n_sym), .polarity(polarity),
        .obf_coeff(obf_coeff), .freq_addr(freq_addr), .freq_data(freq_data),
        .ifft_in_valid(ifft_in_valid), .ifft_in_ready(ifft_in_ready),
        .ifft_in_data(ifft_in_data), .ifft_in_last(ifft_in_last),
        .ifft_out_valid(ifft_out_valid), .ifft_out_data(ifft_out_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done));

    always #5 clk = ~clk;

    logic [W-1:0] rom [N];
    assign freq_data = rom[freq_addr];

    int checks = 0, failures = 0, cyc = 0;
    bit thr = 1'b0;
    logic [W-1:0] blk[$], outq[$], in_log[$];
    bit           in_last_log[$];
    logic [W:0]   out_log[$], exp_q[$];
    int done_cnt, inv_cnt, mv_cnt, stall_err, last_feed_cyc, first_mv_cyc, done_cyc, start_cyc;
    bit timed_out, stalled;
    logic [W:0] held;

    always @(posedge clk) cyc++;

    // Ready throttling and the identity IFFT: replays each collected block, junk otherwise.
    always @(posedge clk) begin
        #1;
        ifft_in_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        m_ready       = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        if (outq.size() > 0) begin
            if (!thr || $urandom_range(0, 2) != 0) begin
                ifft_out_valid = 1'b1;
                ifft_out_data  = outq.pop_front();
                if (outq.size() == 0) last_feed_cyc = cyc;
            end else begin
                ifft_out_valid = 1'b0;
            end
        end else begin
            ifft_out_valid = 1'($urandom_range(0, 1));
            ifft_out_data  = $urandom;
        end
    end

    // Monitor on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            blk.delete();
            outq.delete();
            stalled = 1'b0;
        end else begin
            if (ifft_in_valid) inv_cnt++;
            if (m_valid) mv_cnt++;
            if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
            if (done) done_cnt++;
            if (done && done_cyc < 0) done_cyc = cyc;
            if (ifft_in_valid && ifft_in_ready) begin
                in_log.push_back(ifft_in_data);
                in_last_log.push_back(ifft_in_last);
                blk.push_back(ifft_in_data);
                if (blk.size() == N) begin
                    outq = blk;
                    blk.delete();
                end
            end
            if (stalled && (!m_valid || {m_data, m_last} !== held)) stall_err++;
            stalled = m_valid && !m_ready;
            held    = {m_data, m_last};
            if (m_valid && m_ready) out_log.push_back({m_data, m_last});
        end
    end

    function automatic logic [IQ_W-1:0] m_scale(input logic [IQ_W-1:0] x, input logic [1:0] code);
        int v, sh;
        v = $signed(x);
        case (code)
            2'd0:    sh = 0;
            2'd1:    sh = 3;
            2'd2:    sh = 1;
            default: sh = 2;
        endcase
        v = v >>> sh;
        return IQ_W'(v);
    endfunction

    function automatic logic [IQ_W-1:0] m_neg(input logic [IQ_W-1:0] x);
        int v;
        v = $signed(x);
        v = -v;
        if (v > (1 << (IQ_W - 1)) - 1) v = (1 << (IQ_W - 1)) - 1;
        return IQ_W'(v);
    endfunction

    function automatic logic [W-1:0] m_sample(input int k, input logic [2*N-1:0] coeff);
        logic [1:0] code;
        logic [W-1:0] r;
        code = coeff[2*k +: 2];
        r = rom[k];
        return {m_scale(r[W-1:IQ_W], code), m_scale(r[IQ_W-1:0], code)};
    endfunction

    task automatic build_exp(input int ns, input logic [MS-1:0] pol, input logic [2*N-1:0] coeff);
        int nse, idx;
        logic [W-1:0] v;
        exp_q.delete();
        nse = (ns > MS) ? MS : ns;
        for (int s = 0; s < nse; s++) begin
            for (int p = 0; p < SL; p++) begin
                idx = (p < CP) ? (N - CP + p) : (p - CP);
                v = m_sample(idx, coeff);
                if (pol[s]) v = {m_neg(v[W-1:IQ_W]), m_neg(v[IQ_W-1:0])};
                exp_q.push_back({v, (s == nse - 1) && (p == SL - 1)});
            end
        end
    endtask

    function automatic int first_bad();
        int n;
        n = (out_log.size() < exp_q.size()) ? out_log.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (out_log[i] !== exp_q[i]) return i;
        if (out_log.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic randomize_rom();
        for (int i = 0; i < N; i++) rom[i] = $urandom;
    endtask

    task automatic run_seq(input logic [2:0] ns, input logic [MS-1:0] pol, input logic [2*N-1:0] coeff, input bit poke);
        int waited;
        in_log.delete(); in_last_log.delete(); out_log.delete();
        done_cnt = 0; inv_cnt = 0; mv_cnt = 0; stall_err = 0;
        first_mv_cyc = -1; last_feed_cyc = -1; done_cyc = -1; timed_out = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; n_sym = ns; polarity = pol; obf_coeff = coeff; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; n_sym = 3'($urandom); polarity = MS'($urandom);
        obf_coeff = {$urandom, $urandom, $urandom, $urandom};
        waited = 0;
        while (done_cnt == 0 && waited < 20000) begin
            @(posedge clk); #1;
            waited++;
            start = (poke && (waited == 60 || waited == 300)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        if (waited >= 20000) timed_out = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ifft_in_valid !== 1'b0) begin failures++; $display("FAIL rst_in_valid got=%b exp=0", ifft_in_valid); end
        checks++; if (ifft_in_last !== 1'b0) begin failures++; $display("FAIL rst_in_last got=%b exp=0", ifft_in_last); end
        checks++; if ({m_valid, m_last} !== 2'b00) begin failures++; $display("FAIL rst_m_ctl got=%b exp=00", {m_valid, m_last}); end
        checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL rst_busy_done got=%b exp=00", {busy, done}); end
        checks++; if (freq_addr !== 6'd0) begin failures++; $display("FAIL rst_freq_addr got=%h exp=0", freq_addr); end
        checks++; if (ifft_in_data !== 32'd0 || m_data !== 32'd0) begin failures++; $display("FAIL rst_data got=%h/%h exp=0", ifft_in_data, m_data); end
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_default();
        int bad, lat;
        logic [W-1:0] sat;
        randomize_rom();
        rom[5] = {16'h8000, 16'h1234};
        thr = 1'b0;
        build_exp(2, 4'b0010, '0);
        run_seq(3'd2, 4'b0010, '0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL def_timeout got=1 exp=0"); end
        checks++; if (out_log.size() != 160) begin failures++; $display("FAIL def_count got=%0d exp=160", out_log.size()); end
        bad = first_bad();
        checks++; if (bad !== -1) begin failures++; $display("FAIL def_samples first_bad=%0d", bad); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL def_done got=%0d exp=1", done_cnt); end
        bad = -1;
        for (int k = 0; k < N && k < in_log.size(); k++)
            if (in_log[k] !== rom[k] || in_last_log[k] !== (k == N - 1)) bad = k;
        checks++; if (in_log.size() != N || bad != -1) begin failures++; $display("FAIL def_ifft_in size=%0d bad=%0d exp=%0d/-1", in_log.size(), bad, N); end
        sat = (out_log.size() > SL + CP + 5) ? out_log[SL + CP + 5][W:1] : '0;
        checks++; if (sat[W-1:IQ_W] !== 16'h7FFF) begin failures++; $display("FAIL def_neg_sat got=%h exp=7fff", sat[W-1:IQ_W]); end
        lat = first_mv_cyc - last_feed_cyc;
        checks++; if (lat < 1 || lat > 3) begin failures++; $display("FAIL def_latency got=%0d exp=1..3", lat); end
    endtask

    task automatic test_scale();
        logic [2*N-1:0] coeff;
        int bad;
        randomize_rom();
        for (int k = 1; k < 4; k++) rom[k] = {16'h8000, 16'h0010};
        coeff = {$urandom, $urandom, $urandom, $urandom};
        coeff[3:2] = 2'b01; coeff[5:4] = 2'b10; coeff[7:6] = 2'b11;
        build_exp(1, 4'b0000, coeff);
        run_seq(3'd1, 4'b0000, coeff, 1'b0);
        checks++; if (in_log.size() < 4 || in_log[1] !== 32'hF000_0002) begin failures++; $display("FAIL scale_01 got=%h exp=f0000002", (in_log.size() > 1) ? in_log[1] : 32'hx); end
        checks++; if (in_log.size() < 4 || in_log[2] !== 32'hC000_0008) begin failures++; $display("FAIL scale_10 got=%h exp=c0000008", (in_log.size() > 2) ? in_log[2] : 32'hx); end
        checks++; if (in_log.size() < 4 || in_log[3] !== 32'hE000_0004) begin failures++; $display("FAIL scale_11 got=%h exp=e0000004", (in_log.size() > 3) ? in_log[3] : 32'hx); end
        bad = first_bad();
        checks++; if (bad !== -1) begin failures++; $display("FAIL scale_samples first_bad=%0d", bad); end
    endtask

    task automatic test_throttle();
        logic [2*N-1:0] coeff;
        logic [MS-1:0] pol;
        logic [2:0] ns;
        int bad;
        for (int r = 0; r < 3; r++) begin
            randomize_rom();
            coeff = {$urandom, $urandom, $urandom, $urandom};
            pol = MS'($urandom);
            ns = 3'($urandom_range(1, 4));
            thr = 1'b1;
            build_exp(ns, pol, coeff);
            run_seq(ns, pol, coeff, 1'b1);
            thr = 1'b0;
            bad = first_bad();
            checks++; if (bad !== -1) begin failures++; $display("FAIL thr_samples run=%0d first_bad=%0d got_n=%0d exp_n=%0d", r, bad, out_log.size(), exp_q.size()); end
            checks++; if (stall_err !== 0) begin failures++; $display("FAIL thr_stable run=%0d got=%0d exp=0", r, stall_err); end
            checks++; if (done_cnt !== 1) begin failures++; $display("FAIL thr_done run=%0d got=%0d exp=1", r, done_cnt); end
        end
    endtask

    task automatic test_nsym_zero();
        run_seq(3'd0, 4'b1111, '0, 1'b0);
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zero_done got=%0d exp=1", done_cnt); end
        checks++; if (done_cyc - start_cyc > 2 || done_cyc < 0) begin failures++; $display("FAIL zero_latency got=%0d exp<=2", done_cyc - start_cyc); end
        checks++; if (inv_cnt !== 0 || mv_cnt !== 0) begin failures++; $display("FAIL zero_traffic got=%0d/%0d exp=0/0", inv_cnt, mv_cnt); end
    endtask

    task automatic test_nsym_clamp();
        logic [MS-1:0] pol;
        int bad;
        randomize_rom();
        pol = MS'($urandom);
        build_exp(7, pol, '0);
        run_seq(3'd7, pol, '0, 1'b0);
        checks++; if (out_log.size() != 320) begin failures++; $display("FAIL clamp_count got=%0d exp=320", out_log.size()); end
        bad = first_bad();
        checks++; if (bad !== -1) begin failures++; $display("FAIL clamp_samples first_bad=%0d", bad); end
    endtask

    task automatic test_reset_midplay();
        int waited, bad;
        randomize_rom();
        in_log.delete(); out_log.delete(); done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; n_sym = 3'd2; polarity = 4'b0010; obf_coeff = '0;
        @(posedge clk); #1;
        start = 1'b0;
        waited = 0;
        while (out_log.size() < 37 && waited < 2000) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_log.size() != 37) begin failures++; $display("FAIL mid_abort got=%0d exp=37", out_log.size()); end
        checks++; if (busy !== 1'b0 || done_cnt !== 0) begin failures++; $display("FAIL mid_idle busy=%b done=%0d exp=0/0", busy, done_cnt); end
        build_exp(2, 4'b0010, '0);
        run_seq(3'd2, 4'b0010, '0, 1'b1);
        bad = first_bad();
        checks++; if (bad !== -1) begin failures++; $display("FAIL mid_rerun first_bad=%0d got_n=%0d", bad, out_log.size()); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL mid_done got=%0d exp=1", done_cnt); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; n_sym = 3'd0; polarity = '0; obf_coeff = '0;
        ifft_out_valid = 1'b0; ifft_out_data = '0; ifft_in_ready = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < N; i++) rom[i] = '0;
        test_reset();
        test_default();
        test_scale();
        test_throttle();
        test_nsym_zero();
        test_nsym_clamp();
        test_reset_midplay();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ltf_seq_gen.md
LTF_SEQ_GEN -- requirements
Module: ltf_seq_gen

Interface
REQ-001 SHALL have parameter IQ_W, default 16, meaning bits per I and per Q component; a sample is {I,Q}, 2*IQ_W bits, I in the upper half.
REQ-002 SHALL have parameter LG_N, default 6, meaning log2 of the IFFT size; N = 2^LG_N.
REQ-003 SHALL have parameter CP_LEN, default 16, meaning cyclic-prefix length in samples; legal range 0..N.
REQ-004 SHALL have parameter MAX_SYM, default 4, meaning the maximum number of LTF symbols per sequence.
REQ-005 SHALL have port clk, input, 1 bit, meaning clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-007 SHALL have port start, input, 1 bit, meaning a one-cycle request to generate a sequence.
REQ-008 SHALL have port n_sym, input, 3 bits, meaning the number of LTF symbols; sampled at accepted start.
REQ-009 SHALL have port polarity, input, MAX_SYM bits, meaning bit k=1 negates symbol k; sampled at accepted start.
REQ-010 SHALL have port obf_coeff, input, 2*N bits, meaning the per-subcarrier scale code; bits [2k+1:2k] apply to subcarrier k; sampled at accepted start.
REQ-011 SHALL have port freq_addr, output, LG_N bits, meaning the frequency-ROM address.
REQ-012 SHALL have port freq_data, input, 2*IQ_W bits, meaning the asynchronous ROM data for freq_addr, valid in the same cycle.
REQ-013 SHALL have ports ifft_in_valid/ifft_in_ready/ifft_in_data/ifft_in_last, out/in/out/out, 1/1/2*IQ_W/1 bits, meaning the stream to the external IFFT.
REQ-014 SHALL have ports ifft_out_valid/ifft_out_data, input/input, 1/2*IQ_W bits, meaning the IFFT result stream; it has no backpressure.
REQ-015 SHALL have ports m_valid/m_ready/m_data/m_last, out/in/out/out, 1/1/2*IQ_W/1 bits, meaning the time-domain output stream.
REQ-016 SHALL have ports busy/done, output/output, 1/1 bit, meaning busy is high outside IDLE and done is a one-cycle pulse at sequence end.

Function
REQ-017 SHALL implement the states IDLE, LOAD, CAPTURE, PLAY and FINISH.
REQ-018 In IDLE, start SHALL latch the inputs and go to LOAD; start outside IDLE SHALL be ignored.
REQ-019 n_sym values above MAX_SYM SHALL be clamped to MAX_SYM.
REQ-020 n_sym=0 SHALL go from IDLE to FINISH with no IFFT or m_* traffic, and done SHALL pulse.
REQ-021 In LOAD, freq_addr SHALL equal the load counter k (0..N-1).
REQ-022 In LOAD, ifft_in_valid SHALL be 1 and ifft_in_data SHALL be freq_data scaled per code for subcarrier k.
REQ-023 The scale codes SHALL be: 00 = x1, 01 = arithmetic shift right by 3, 10 = arithmetic shift right by 1, 11 = arithmetic shift right by 2; I and Q are shifted independently with sign extension.
REQ-024 k SHALL advance only on ifft_in_valid & ifft_in_ready.
REQ-025 ifft_in_last SHALL be high at k=N-1; the transfer at k=N-1 SHALL move the block to CAPTURE.
REQ-026 In CAPTURE, each ifft_out_valid SHALL write ifft_out_data into buffer[c], c=0..N-1; the write at c=N-1 SHALL move the block to PLAY.
REQ-027 ifft_out_valid outside CAPTURE SHALL be dropped.
REQ-028 In PLAY, symbol s (0..n_sym-1) SHALL output buffer[N-CP_LEN..N-1] followed by buffer[0..N-1], i.e. N+CP_LEN samples.
REQ-029 If polarity[s]=1, each component of symbol s SHALL be negated in two's complement, with -2^(IQ_W-1) saturating to 2^(IQ_W-1)-1.
REQ-030 The output SHALL be AXI-stream: m_data/m_last SHALL be held stable while m_valid & !m_ready; position advances only on handshake; the buffer read path SHALL add no bubbles at m_ready=1.
REQ-031 m_last SHALL be high on the final sample of the final symbol only.
REQ-032 FINISH SHALL pulse done for 1 cycle, then return to IDLE; minimum 1 IDLE cycle before a new start is accepted.
REQ-033 The first m_valid SHALL be at most 2 cycles after the CAPTURE->PLAY transition.

Reset
REQ-034 Reset SHALL force IDLE and clear all counters.
REQ-035 During reset, ifft_in_valid, ifft_in_last, m_valid, m_last, busy and done SHALL be 0; freq_addr and data outputs SHALL be 0.
REQ-036 Reset mid-sequence SHALL abort at the next edge, with no further m_* or IFFT handshakes.
REQ-037 Buffer contents need not be cleared by reset.

Verification
REQ-038 Defaults with n_sym=2, polarity=2'b10, obf_coeff=0, and an identity-model IFFT -> exactly 160 m_* transfers; symbol 0 = ROM[48..63],ROM[0..63]; symbol 1 = the negation of the same; m_last only on transfer 160; done pulses once.
REQ-039 obf_coeff codes 01/10/11 with ROM sample {16'h8000,16'h0010} -> ifft_in_data {F000,0002}, {C000,0008} and {E000,0004} respectively.
REQ-040 A buffer entry of I=16'h8000 with polarity bit set -> output I=16'h7FFF.
REQ-041 Random m_ready and ifft_in_ready throttling -> sample sequence identical to the unthrottled run, and outputs stable while stalled.
REQ-042 n_sym=0 -> done within 2 cycles and no valid asserted; n_sym=7 -> 4 symbols (320 samples).
REQ-043 Reset asserted at PLAY sample 37, then start reissued -> a complete, correct 160-sample sequence follows; start during busy is ignored.
